// File: rtl/dmem_pkg.sv
// Shared types and elaboration-time parameter checks for the data memory.
package dmem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dmem_state_t;

    // True when the parameter set is usable: whole bytes per word and the
    // array fits inside the word-address space.
    function automatic bit dmem_params_ok(input int data_w, input int addr_w, input int depth);
        longint cap;
        cap = (addr_w >= 62) ? 64'h3fff_ffff_ffff_ffff : (longint'(1) << addr_w);
        return (data_w > 0) && (data_w % 8 == 0) && (depth > 0) && (longint'(depth) <= cap);
    endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port SRAM with per-byte write enables and a write-first read port.
module sram_1rw_be #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NB    = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [NB-1:0]     i_be,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_merged;

    // Old word with the enabled byte lanes replaced by the write data.
    always_comb begin
        w_merged = r_mem[i_addr];
        for (int b = 0; b < NB; b++) begin
            if (i_be[b]) w_merged[8*b +: 8] = i_wdata[8*b +: 8];
        end
    end

    // Array write and registered read; a write returns the merged word.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) r_mem[i_addr] <= w_merged;
            o_q <= i_we ? w_merged : r_mem[i_addr];
        end
    end

endmodule

// File: rtl/dmem_sram.sv
// MEM-stage data memory: request/response handshake, byte writes,
// out-of-range detection and a one-word-per-cycle clear sweep.
module dmem_sram
    import dmem_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int DEPTH          = 512,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_req,
    output logic                busy,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB = DATA_W / 8;

    if (!dmem_params_ok(DATA_W, ADDR_W, DEPTH)) begin : g_param_err
        $error("dmem_sram: DATA_W must be a multiple of 8 and DEPTH <= 2**ADDR_W");
    end

    dmem_state_t       r_state, w_state_nxt;
    logic [PW-1:0]     r_ptr;
    logic              w_clearing, w_accept, w_in_range;
    logic              r_rsp_valid, r_rsp_err;
    logic [DATA_W-1:0] r_rdata_hold, w_rsp_rdata, w_sram_q;
    logic              w_sram_en, w_sram_we;
    logic [NB-1:0]     w_sram_be;
    logic [PW-1:0]     w_sram_addr;
    logic [DATA_W-1:0] w_sram_wdata;

    assign w_accept   = req_valid && req_ready;
    assign w_in_range = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);

    // Controller state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
        else        r_state <= w_state_nxt;
    end

    // Next state and handshake outputs; ready is also held low during reset.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        req_ready   = 1'b0;
        w_clearing  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                busy       = 1'b1;
                w_clearing = 1'b1;
                if (r_ptr == PW'(DEPTH - 1)) w_state_nxt = ST_READY;
            end
            ST_READY: begin
                req_ready = reset;
                if (clear_req) w_state_nxt = ST_CLEAR;
            end
            default: w_state_nxt = ST_READY;
        endcase
    end

    // Clear pointer walks the array during a sweep and parks at zero otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         r_ptr <= '0;
        else if (w_clearing && r_ptr != PW'(DEPTH - 1)) r_ptr <= r_ptr + 1'b1;
        else                                r_ptr <= '0;
    end

    // SRAM port mux: the sweep owns the port in CLEAR, requests otherwise.
    always_comb begin
        w_sram_en    = 1'b0;
        w_sram_we    = 1'b0;
        w_sram_be    = '0;
        w_sram_addr  = '0;
        w_sram_wdata = '0;
        if (w_clearing) begin
            w_sram_en   = 1'b1;
            w_sram_we   = 1'b1;
            w_sram_be   = '1;
            w_sram_addr = r_ptr;
        end else if (w_accept && w_in_range) begin
            w_sram_en    = 1'b1;
            w_sram_we    = req_we;
            w_sram_be    = req_be;
            w_sram_addr  = req_addr[PW-1:0];
            w_sram_wdata = req_wdata;
        end
    end

    sram_1rw_be #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_sram (
        .i_clk   (clk),
        .i_en    (w_sram_en),
        .i_we    (w_sram_we),
        .i_be    (w_sram_be),
        .i_addr  (w_sram_addr),
        .i_wdata (w_sram_wdata),
        .o_q     (w_sram_q)
    );

    // The SRAM output moves during a sweep, so the shown response word is
    // latched once its valid cycle ends and replayed until the next one.
    assign w_rsp_rdata = r_rsp_err ? '0 : w_sram_q;
    assign rsp_rdata   = r_rsp_valid ? w_rsp_rdata : r_rdata_hold;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp_err;

    // Response valid pulse, error flag and held read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept)    r_rsp_err    <= ~w_in_range;
            if (r_rsp_valid) r_rdata_hold <= w_rsp_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_sram.sv
// Randomised self-checking bench for dmem_sram against an array model.
module tb_dmem_sram;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear_req = 1'b0;
    logic        busy;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_be = 2'b00;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mdl [DEPTH];

    dmem_sram #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) mdl[i] = 16'h0;
    endfunction

    // Reference behaviour of one accepted request.
    function automatic void model_access(input logic we, input logic [1:0] be,
                                         input logic [15:0] a, input logic [15:0] wd,
                                         output logic [15:0] ed, output logic ee);
        if (int'(a) >= DEPTH) begin
            ed = 16'h0; ee = 1'b1;
        end else begin
            if (we) for (int b = 0; b < 2; b++) if (be[b]) mdl[a][8*b +: 8] = wd[8*b +: 8];
            ed = mdl[a]; ee = 1'b0;
        end
    endfunction

    // One cycle: drive at the falling edge, sample the response at the next one.
    task automatic step(input logic v, input logic we, input logic [1:0] be,
                        input logic [15:0] a, input logic [15:0] wd, input logic clr,
                        output logic acc, output logic ov, output logic [15:0] od,
                        output logic oe);
        req_valid = v; req_we = we; req_be = be; req_addr = a; req_wdata = wd;
        clear_req = clr;
        #1;
        acc = v && req_ready;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; clear_req = 1'b0;
        ov = rsp_valid; od = rsp_rdata; oe = rsp_err;
    endtask

    // Counts busy cycles from the current falling edge (bounded).
    task automatic wait_sweep(input int pulse_at, output int cnt,
                              output bit rdy_bad, output bit vld_bad);
        cnt = 0; rdy_bad = 0; vld_bad = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            if (req_ready !== 1'b0) rdy_bad = 1;
            if (cnt > 0 && rsp_valid !== 1'b0) vld_bad = 1;
            cnt++;
            clear_req = (cnt == pulse_at);
            @(negedge clk);
        end
        clear_req = 1'b0;
    endtask

    task automatic test_reset();
        logic acc, ov, oe; logic [15:0] od, ed; logic ee;
        int cnt; bit rb, vb;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, req_ready, rsp_valid, rsp_err, rsp_rdata} !== {4'b1000, 16'h0})
            $display("FAIL reset_vals got busy=%b rdy=%b vld=%b err=%b rd=%h want 1 0 0 0 0000",
                     busy, req_ready, rsp_valid, rsp_err, rsp_rdata);
        else n_pass++;
        reset = 1'b1;
        wait_sweep(-1, cnt, rb, vb);
        model_clear();
        n_checks++;
        if (cnt !== DEPTH) $display("FAIL reset_sweep_len got %0d want %0d", cnt, DEPTH);
        else n_pass++;
        n_checks++;
        if (rb || vb || req_ready !== 1'b1)
            $display("FAIL reset_sweep_hs got rdy_bad=%0d vld_bad=%0d rdy_after=%b want 0 0 1", rb, vb, req_ready);
        else n_pass++;
        step(1, 0, 2'b00, 16'h01FF, 16'h0, 0, acc, ov, od, oe);
        model_access(0, 2'b00, 16'h01FF, 16'h0, ed, ee);
        n_checks++;
        if (!acc || ov !== 1'b1 || od !== ed || oe !== ee)
            $display("FAIL read_top_after_clear got acc=%b v=%b d=%h e=%b want 1 1 %h %b", acc, ov, od, oe, ed, ee);
        else n_pass++;
    endtask

    task automatic test_byte_merge();
        logic acc, ov, oe; logic [15:0] od, ed; logic ee;
        step(1, 1, 2'b11, 16'h0010, 16'hBEEF, 0, acc, ov, od, oe);
        model_access(1, 2'b11, 16'h0010, 16'hBEEF, ed, ee);
        n_checks++;
        if (ov !== 1'b1 || od !== ed || oe !== ee) $display("FAIL merge_full got v=%b d=%h want 1 %h", ov, od, ed);
        else n_pass++;
        step(1, 1, 2'b01, 16'h0010, 16'h1234, 0, acc, ov, od, oe);
        model_access(1, 2'b01, 16'h0010, 16'h1234, ed, ee);
        n_checks++;
        if (ov !== 1'b1 || od !== ed || od !== 16'hBE34) $display("FAIL merge_low got d=%h want %h", od, ed);
        else n_pass++;
        step(1, 1, 2'b00, 16'h0010, 16'hFFFF, 0, acc, ov, od, oe);
        model_access(1, 2'b00, 16'h0010, 16'hFFFF, ed, ee);
        n_checks++;
        if (ov !== 1'b1 || od !== ed) $display("FAIL merge_be0 got v=%b d=%h want 1 %h", ov, od, ed);
        else n_pass++;
        step(1, 0, 2'b00, 16'h0010, 16'h0, 0, acc, ov, od, oe);
        model_access(0, 2'b00, 16'h0010, 16'h0, ed, ee);
        n_checks++;
        if (ov !== 1'b1 || od !== ed) $display("FAIL merge_readback got d=%h want %h", od, ed);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic acc1, ov1, oe1, acc2, ov2, oe2; logic [15:0] od1, od2, ed1, ed2; logic ee;
        step(1, 1, 2'b11, 16'h0005, 16'hA5A5, 0, acc1, ov1, od1, oe1);
        step(1, 0, 2'b00, 16'h0005, 16'h0, 0, acc2, ov2, od2, oe2);
        model_access(1, 2'b11, 16'h0005, 16'hA5A5, ed1, ee);
        model_access(0, 2'b00, 16'h0005, 16'h0, ed2, ee);
        n_checks++;
        if (!acc1 || !acc2 || ov1 !== 1'b1 || ov2 !== 1'b1)
            $display("FAIL b2b_pulses got acc=%b%b v=%b%b want 11 11", acc1, acc2, ov1, ov2);
        else n_pass++;
        n_checks++;
        if (od1 !== ed1 || od2 !== ed2) $display("FAIL b2b_data got %h %h want %h %h", od1, od2, ed1, ed2);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic acc, ov, oe; logic [15:0] od, ed; logic ee;
        step(1, 1, 2'b11, 16'h0000, 16'h5A5A, 0, acc, ov, od, oe);
        model_access(1, 2'b11, 16'h0000, 16'h5A5A, ed, ee);
        step(1, 1, 2'b11, 16'h0200, 16'hFFFF, 0, acc, ov, od, oe);
        model_access(1, 2'b11, 16'h0200, 16'hFFFF, ed, ee);
        step(1, 0, 2'b00, 16'h0200, 16'h0, 0, acc, ov, od, oe);
        model_access(0, 2'b00, 16'h0200, 16'h0, ed, ee);
        n_checks++;
        if (ov !== 1'b1 || od !== ed || oe !== ee) $display("FAIL oor_read got v=%b d=%h e=%b want 1 %h %b", ov, od, oe, ed, ee);
        else n_pass++;
        step(1, 0, 2'b00, 16'h0000, 16'h0, 0, acc, ov, od, oe);
        model_access(0, 2'b00, 16'h0000, 16'h0, ed, ee);
        n_checks++;
        if (ov !== 1'b1 || od !== ed || oe !== ee) $display("FAIL oor_no_wrap got d=%h e=%b want %h %b", od, oe, ed, ee);
        else n_pass++;
        step(0, 0, 2'b00, 16'h0000, 16'h0, 0, acc, ov, od, oe);
        n_checks++;
        if (ov !== 1'b0 || od !== ed || oe !== ee) $display("FAIL rsp_hold got v=%b d=%h e=%b want 0 %h %b", ov, od, oe, ed, ee);
        else n_pass++;
    endtask

    task automatic test_clear_with_write();
        logic acc, ov, oe; logic [15:0] od, ed; logic ee; int cnt; bit rb, vb;
        step(1, 1, 2'b11, 16'h0003, 16'h7777, 1, acc, ov, od, oe);
        model_access(1, 2'b11, 16'h0003, 16'h7777, ed, ee);
        n_checks++;
        if (!acc || ov !== 1'b1 || od !== ed || busy !== 1'b1)
            $display("FAIL clr_ack got acc=%b v=%b d=%h busy=%b want 1 1 %h 1", acc, ov, od, busy, ed);
        else n_pass++;
        wait_sweep(100, cnt, rb, vb);
        model_clear();
        n_checks++;
        if (cnt !== DEPTH || rb || vb) $display("FAIL clr_sweep got len=%0d rdy_bad=%0d vld_bad=%0d want %0d 0 0", cnt, rb, vb, DEPTH);
        else n_pass++;
        step(1, 0, 2'b00, 16'h0003, 16'h0, 0, acc, ov, od, oe);
        model_access(0, 2'b00, 16'h0003, 16'h0, ed, ee);
        n_checks++;
        if (ov !== 1'b1 || od !== ed) $display("FAIL clr_readback got d=%h want %h", od, ed);
        else n_pass++;
    endtask

    task automatic test_reset_midsweep();
        logic acc, ov, oe; logic [15:0] od, ed; logic ee; int cnt; bit rb, vb;
        step(1, 1, 2'b11, 16'd200, 16'h1111, 0, acc, ov, od, oe);
        model_access(1, 2'b11, 16'd200, 16'h1111, ed, ee);
        step(1, 0, 2'b00, 16'd200, 16'h0, 1, acc, ov, od, oe);
        repeat (100) @(negedge clk);
        n_checks++;
        if (rsp_rdata !== ed || busy !== 1'b1) $display("FAIL midsweep_hold got d=%h busy=%b want %h 1", rsp_rdata, busy, ed);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, req_ready, rsp_valid, rsp_err, rsp_rdata} !== {4'b1000, 16'h0})
            $display("FAIL midsweep_reset got busy=%b rdy=%b vld=%b err=%b rd=%h want 1 0 0 0 0000",
                     busy, req_ready, rsp_valid, rsp_err, rsp_rdata);
        else n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_sweep(-1, cnt, rb, vb);
        model_clear();
        n_checks++;
        if (cnt !== DEPTH || rb || vb) $display("FAIL midsweep_rerun got len=%0d rdy_bad=%0d vld_bad=%0d want %0d 0 0", cnt, rb, vb, DEPTH);
        else n_pass++;
        step(1, 0, 2'b00, 16'd200, 16'h0, 0, acc, ov, od, oe);
        model_access(0, 2'b00, 16'd200, 16'h0, ed, ee);
        n_checks++;
        if (ov !== 1'b1 || od !== ed) $display("FAIL midsweep_read got d=%h want %h", od, ed);
        else n_pass++;
    endtask

    task automatic test_random();
        logic acc, ov, oe, v, we, ee; logic [1:0] be; logic [15:0] a, wd, od, ed;
        logic [15:0] last_d; logic last_e;
        last_d = rsp_rdata; last_e = rsp_err;
        for (int i = 0; i < 300; i++) begin
            v  = ($urandom_range(0, 4) != 0);
            we = 1'($urandom_range(0, 1));
            be = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 16'(DEPTH + $urandom_range(0, 63)) : 16'($urandom_range(0, 31));
            wd = 16'($urandom);
            step(v, we, be, a, wd, 0, acc, ov, od, oe);
            n_checks++;
            if (acc) begin
                model_access(we, be, a, wd, ed, ee);
                if (ov !== 1'b1 || od !== ed || oe !== ee)
                    $display("FAIL rand_%0d got v=%b d=%h e=%b want 1 %h %b (we=%b be=%b a=%h)", i, ov, od, oe, ed, ee, we, be, a);
                else n_pass++;
                last_d = ed; last_e = ee;
            end else begin
                if (ov !== 1'b0 || od !== last_d || oe !== last_e || v)
                    $display("FAIL rand_idle_%0d got v=%b d=%h e=%b req=%b want 0 %h %b 0", i, ov, od, oe, v, last_d, last_e);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_merge();
        test_back_to_back();
        test_out_of_range();
        test_clear_with_write();
        test_reset_midsweep();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
